// File: rtl/ic_7400_pkg.sv
// Shared constants and helpers for the 7400 quad NAND model and its observation layer.
// Optional stuck-at fault injection is enabled with the IC_7400_STUCK_FAULT_EN macro.
package ic_7400_pkg;

  localparam int GATES_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int GATES_MAX = 8;

  // Registered output value out of reset: NAND of idle-low inputs is high.
  localparam logic [GATES_MAX-1:0] Y_RST = '1;

  // Saturating increment: holds at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    return (value >= max) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ic_7400_quad_nand_gate_obs.sv
// One NAND gate with its registered copy, change pulse and saturating toggle counter.
// With IC_7400_STUCK_FAULT_EN the gate output can be forced to a stuck value.
module nand_gate_obs
  import ic_7400_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
`ifdef IC_7400_STUCK_FAULT_EN
  input  logic             fault_en,
  input  logic             fault_val,
`endif
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic             y_edge,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  // A 0 on either input yields 1 even when the other input is X.
`ifdef IC_7400_STUCK_FAULT_EN
  assign y = fault_en ? fault_val : ~(a & b);
`else
  assign y = ~(a & b);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= Y_RST[0];
      y_edge <= 1'b0;
      cnt    <= '0;
    end else begin
      y_q    <= y;
      y_edge <= y ^ y_q;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (y != y_q) begin
        cnt <= CNT_W'(sat_inc(32'(cnt), CNT_MAX));
      end
    end
  end

endmodule

// File: rtl/ic_7400_quad_nand.sv
// Quad (GATES-wide) 2-input NAND with a clocked debug/coverage observation layer.
// Define IC_7400_STUCK_FAULT_EN to add fault_en/fault_val stuck-at injection ports.
module ic_7400_quad_nand
  import ic_7400_pkg::*;
#(
  parameter int GATES = GATES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [GATES-1:0]       a,
  input  logic [GATES-1:0]       b,
`ifdef IC_7400_STUCK_FAULT_EN
  input  logic [GATES-1:0]       fault_en,
  input  logic [GATES-1:0]       fault_val,
`endif
  input  logic                   cnt_clr,
  output logic [GATES-1:0]       y,
  output logic [GATES-1:0]       y_q,
  output logic [GATES-1:0]       y_edge,
  output logic [GATES*CNT_W-1:0] toggle_cnt
);

  for (genvar g = 0; g < GATES; g++) begin : g_gate
    nand_gate_obs #(
      .CNT_W(CNT_W)
    ) u_gate (
      .clk      (clk),
      .rst      (rst),
      .a        (a[g]),
      .b        (b[g]),
`ifdef IC_7400_STUCK_FAULT_EN
      .fault_en (fault_en[g]),
      .fault_val(fault_val[g]),
`endif
      .cnt_clr  (cnt_clr),
      .y        (y[g]),
      .y_q      (y_q[g]),
      .y_edge   (y_edge[g]),
      .cnt      (toggle_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_ic_7400_quad_nand.sv
// Self-checking bench for ic_7400_quad_nand against a per-gate behavioural model.
// Fault-injection scenarios are included when IC_7400_STUCK_FAULT_EN is defined.
module tb_ic_7400_quad_nand;

  localparam int GATES   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [GATES-1:0]       a = '0;
  logic [GATES-1:0]       b = '0;
  logic                   cnt_clr = 1'b0;
  logic [GATES-1:0]       y;
  logic [GATES-1:0]       y_q;
  logic [GATES-1:0]       y_edge;
  logic [GATES*CNT_W-1:0] toggle_cnt;
`ifdef IC_7400_STUCK_FAULT_EN
  logic [GATES-1:0]       fault_en = '0;
  logic [GATES-1:0]       fault_val = '0;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model state, one entry per gate.
  bit m_yq[GATES];
  bit m_edge[GATES];
  int m_cnt[GATES];

  ic_7400_quad_nand #(
    .GATES(GATES),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
`ifdef IC_7400_STUCK_FAULT_EN
    .fault_en  (fault_en),
    .fault_val (fault_val),
`endif
    .cnt_clr   (cnt_clr),
    .y         (y),
    .y_q       (y_q),
    .y_edge    (y_edge),
    .toggle_cnt(toggle_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit ref_y(int i);
`ifdef IC_7400_STUCK_FAULT_EN
    if (fault_en[i]) return fault_val[i];
`endif
    return !(a[i] == 1'b1 && b[i] == 1'b1);
  endfunction

  function automatic logic [GATES-1:0] exp_y();
    logic [GATES-1:0] v;
    for (int i = 0; i < GATES; i++) v[i] = ref_y(i);
    return v;
  endfunction

  function automatic logic [GATES-1:0] exp_yq();
    logic [GATES-1:0] v;
    for (int i = 0; i < GATES; i++) v[i] = m_yq[i];
    return v;
  endfunction

  function automatic logic [GATES-1:0] exp_edge();
    logic [GATES-1:0] v;
    for (int i = 0; i < GATES; i++) v[i] = m_edge[i];
    return v;
  endfunction

  function automatic logic [GATES*CNT_W-1:0] exp_cnt();
    logic [GATES*CNT_W-1:0] v;
    for (int i = 0; i < GATES; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    return v;
  endfunction

  // Advance one rising edge; the model consumes the inputs present at the edge.
  task automatic tick();
    bit ym[GATES];
    @(posedge clk);
    for (int i = 0; i < GATES; i++) ym[i] = ref_y(i);
    for (int i = 0; i < GATES; i++) begin
      if (rst) begin
        m_yq[i]   = 1'b1;
        m_edge[i] = 1'b0;
        m_cnt[i]  = 0;
      end else begin
        m_edge[i] = (ym[i] != m_yq[i]);
        if (cnt_clr) m_cnt[i] = 0;
        else if (ym[i] != m_yq[i]) m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
        m_yq[i] = ym[i];
      end
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_truth_table();
    logic [GATES-1:0] exp_v;
    a = '0;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      a[0] = k[1];
      b[0] = k[0];
      #1;
      exp_v = (k == 3) ? 4'b1110 : 4'b1111;
      checks++;
      if (y !== exp_v) begin
        errors++;
        $display("FAIL truth_table a0=%0d b0=%0d: y=%b required %b", k[1], k[0], y, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    tick();
    tick();
    checks++;
    if (y !== 4'h0 || y_q !== 4'hF || y_edge !== 4'h0 || toggle_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: y=%h y_q=%h y_edge=%h cnt=%h required 0 f 0 0000",
               y, y_q, y_edge, toggle_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (y_q !== 4'h0 || y_edge !== 4'hF || toggle_cnt !== 16'h1111) begin
      errors++;
      $display("FAIL reset_release: y_q=%h y_edge=%h cnt=%h required 0 f 1111",
               y_q, y_edge, toggle_cnt);
    end
    tick();
    checks++;
    if (y_edge !== 4'h0 || toggle_cnt !== 16'h1111) begin
      errors++;
      $display("FAIL reset_settle: y_edge=%h cnt=%h required 0 1111", y_edge, toggle_cnt);
    end
  endtask

  task automatic test_independence();
    int snap[GATES];
    logic [CNT_W-1:0] got;
    a = 4'b0101;
    b = 4'b0111;
    #1;
    checks++;
    if (y !== 4'b1010) begin
      errors++;
      $display("FAIL independence_y: y=%b required 1010", y);
    end
    tick();
    tick();
    for (int i = 0; i < GATES; i++) snap[i] = m_cnt[i];
    for (int k = 0; k < 5; k++) begin
      a[2] = ~a[2];
      tick();
    end
    for (int i = 0; i < GATES; i++) begin
      got = toggle_cnt[i*CNT_W +: CNT_W];
      checks++;
      if (i == 2) begin
        if (got !== CNT_W'((snap[i] + 5 > CNT_MAX) ? CNT_MAX : snap[i] + 5)) begin
          errors++;
          $display("FAIL independence_cnt gate%0d: cnt=%0d required %0d", i, got, snap[i] + 5);
        end
      end else if (got !== CNT_W'(snap[i])) begin
        errors++;
        $display("FAIL independence_cnt gate%0d: cnt=%0d required %0d", i, got, snap[i]);
      end
    end
  endtask

  task automatic test_latency();
    a = 4'b0000;
    b = 4'b0010;
    tick();
    tick();
    a[1] = 1'b1;
    #1;
    checks++;
    if (y[1] !== 1'b0 || y_q[1] !== 1'b1) begin
      errors++;
      $display("FAIL latency_comb: y1=%b y_q1=%b required 0 1", y[1], y_q[1]);
    end
    tick();
    checks++;
    if (y_q !== 4'b1101 || y_edge !== 4'b0010) begin
      errors++;
      $display("FAIL latency_edge: y_q=%b y_edge=%b required 1101 0010", y_q, y_edge);
    end
    tick();
    checks++;
    if (y_q !== 4'b1101 || y_edge !== 4'b0000) begin
      errors++;
      $display("FAIL latency_pulse_end: y_q=%b y_edge=%b required 1101 0000", y_q, y_edge);
    end
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (toggle_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL clear: cnt=%h required 0000", toggle_cnt);
    end
    b[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a[3] = ~a[3];
      tick();
    end
    checks++;
    if (toggle_cnt[3*CNT_W +: CNT_W] !== 4'd15 || toggle_cnt !== exp_cnt()) begin
      errors++;
      $display("FAIL saturate: cnt=%h required gate3=15 total %h", toggle_cnt, exp_cnt());
    end
    cnt_clr = 1'b1;
    tick();
    checks++;
    if (toggle_cnt[3*CNT_W +: CNT_W] !== 4'd0) begin
      errors++;
      $display("FAIL clear_after_sat: cnt3=%0d required 0", toggle_cnt[3*CNT_W +: CNT_W]);
    end
    a[3] = ~a[3];
    tick();
    checks++;
    if (toggle_cnt[3*CNT_W +: CNT_W] !== 4'd0) begin
      errors++;
      $display("FAIL clear_priority: cnt3=%0d required 0", toggle_cnt[3*CNT_W +: CNT_W]);
    end
    cnt_clr = 1'b0;
    a[3] = ~a[3];
    tick();
    checks++;
    if (toggle_cnt[3*CNT_W +: CNT_W] !== 4'd1) begin
      errors++;
      $display("FAIL count_after_clear: cnt3=%0d required 1", toggle_cnt[3*CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_reset_mid();
    a = 4'b1010;
    b = 4'b1111;
    tick();
    a = 4'b0011;
    b = 4'b0001;
    rst = 1'b1;
    tick();
    checks++;
    if (y_q !== 4'hF || y_edge !== 4'h0 || toggle_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: y_q=%h y_edge=%h cnt=%h required f 0 0000", y_q, y_edge, toggle_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (y_q !== 4'b1110 || y_edge !== 4'b0001 || toggle_cnt !== 16'h0001) begin
      errors++;
      $display("FAIL reset_mid_release: y_q=%b y_edge=%b cnt=%h required 1110 0001 0001",
               y_q, y_edge, toggle_cnt);
    end
  endtask

`ifdef IC_7400_STUCK_FAULT_EN
  task automatic test_fault();
    a = '0;
    b = '0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tick();
    fault_en  = 4'b0001;
    fault_val = 4'b0000;
    #1;
    checks++;
    if (y !== 4'b1110) begin
      errors++;
      $display("FAIL fault_force: y=%b required 1110", y);
    end
    tick();
    checks++;
    if (y_q !== 4'b1110 || toggle_cnt !== 16'h0001) begin
      errors++;
      $display("FAIL fault_observe: y_q=%b cnt=%h required 1110 0001", y_q, toggle_cnt);
    end
    fault_en = 4'b0000;
    #1;
    checks++;
    if (y !== 4'b1111) begin
      errors++;
      $display("FAIL fault_release: y=%b required 1111", y);
    end
    tick();
    checks++;
    if (toggle_cnt !== 16'h0002) begin
      errors++;
      $display("FAIL fault_release_cnt: cnt=%h required 0002", toggle_cnt);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      a       = GATES'($urandom_range(0, 15));
      b       = GATES'($urandom_range(0, 15));
      cnt_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 31) == 0);
`ifdef IC_7400_STUCK_FAULT_EN
      fault_en  = ($urandom_range(0, 3) == 0) ? GATES'($urandom_range(0, 15)) : '0;
      fault_val = GATES'($urandom_range(0, 15));
`endif
      #1;
      checks++;
      if (y !== exp_y()) begin
        errors++;
        $display("FAIL random_y cycle %0d: y=%b required %b", k, y, exp_y());
      end
      tick();
      checks++;
      if (y_q !== exp_yq() || y_edge !== exp_edge() || toggle_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL random_regs cycle %0d: y_q=%b y_edge=%b cnt=%h required %b %b %h",
                 k, y_q, y_edge, toggle_cnt, exp_yq(), exp_edge(), exp_cnt());
      end
    end
    rst     = 1'b0;
    cnt_clr = 1'b0;
`ifdef IC_7400_STUCK_FAULT_EN
    fault_en = '0;
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < GATES; i++) begin
      m_yq[i]   = 1'b1;
      m_edge[i] = 1'b0;
      m_cnt[i]  = 0;
    end
    test_truth_table();
    test_reset();
    test_independence();
    test_latency();
    test_saturation();
    test_reset_mid();
`ifdef IC_7400_STUCK_FAULT_EN
    test_fault();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
